inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, field set present.
REQ-004 SHALL have port in_ready, output, 1, field set accepted when in_valid&in_ready.
REQ-005 SHALL have port in_fmt, input, 2, format: 0=R, 1=I, 2=J, 3=reserved.
REQ-006 SHALL have field ports: in_op (input, 6), in_rs (input, 5), in_rt (input, 5), in_rd (input, 5), in_shamt (input, 5), in_func (input, 6), in_imm (input, 16), in_target (input, 26).
REQ-007 SHALL have port in_last, input, 1, marks final field set of a program.
REQ-008 SHALL have port out_valid, output, 1, encoded word available.
REQ-009 SHALL have port out_ready, input, 1, sink (instruction-memory writer) accepts word.
REQ-010 SHALL have port out_word, output, 32, encoded instruction.
REQ-011 SHALL have port out_addr, output, 10, word address of out_word.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when program fully drained.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on rejected field set (macro only; else tied 0).
REQ-014 SHALL have port err_cnt, output, 8, saturating count of rejected sets (macro only; else tied 0).

Function
REQ-015 SHALL encode: R -> {6'b0, rs, rt, rd, shamt, func} (in_op ignored); I -> {op, rs, rt, imm}; J -> {op, target}; fmt 3 encodes as I when the macro is absent.
REQ-016 SHALL buffer encoded words in a 2-entry FIFO; in_ready = FIFO not full (combinational from registered state only, not from out_ready).
REQ-017 SHALL present a word on out_valid the cycle after acceptance when the FIFO was empty (latency 1).
REQ-018 SHALL hold out_word/out_addr stable while out_valid & !out_ready.
REQ-019 SHALL support simultaneous push and pop when full, FIFO count unchanged, no drop.
REQ-020 SHALL keep a 10-bit address counter, incremented per output handshake, wrapping 1023 -> 0.
REQ-021 SHALL implement FSM IDLE -> RUN (first accept) -> FLUSH (accept with in_last) -> DONE (FIFO empty) -> IDLE; DONE lasts exactly 1 cycle with done=1.
REQ-022 SHALL deassert in_ready in FLUSH and DONE; reset address counter to 0 on DONE -> IDLE.
REQ-023 SHALL treat a single accepted set with in_last as IDLE -> FLUSH directly.

Reset
REQ-024 SHALL, with rst_n=0 at a clock edge, clear FIFO, FSM=IDLE, address=0, err_cnt=0; outputs: out_valid=0, done=0, err=0, in_ready=0 during reset, 1 the cycle after release.
REQ-025 SHALL discard any buffered words on reset asserted mid-program; no done pulse.

Configuration
REQ-026 SHALL compile opcode checking in with macro INST_ENCODER_CHECK_EN.
REQ-027 SHALL, with INST_ENCODER_CHECK_EN defined, reject fmt 3 and any I/J opcode outside {1..15, 32, 33, 35, 36, 37, 40, 41, 43}, and reject J with op not 2/3: set not pushed, address not advanced, err pulses the cycle after acceptance, err_cnt +1 saturating at 255; in_last on a rejected set still enters FLUSH.
REQ-028 SHALL, without the macro, encode every set and tie err/err_cnt to 0.

Verification
REQ-029 SHALL verify: I op=8 rs=9 rt=8 imm=5 -> out_word 0x21280005, out_addr 0, out_valid one cycle after accept.
REQ-030 SHALL verify: R rs=1 rt=2 rd=3 shamt=0 func=0x20, in_op=0x3F -> 0x00221820.
REQ-031 SHALL verify: J op=2 target=0x0100000 with in_last -> 0x08100000, then done pulse 1 cycle after drain, address back to 0.
REQ-032 SHALL verify: out_ready=0 for 5 cycles with 3 sets offered -> 2 buffered, in_ready=0, words then drain in order at addr 0,1.
REQ-033 SHALL verify: 1025 words streamed -> addresses 0..1023 then 0.
REQ-034 SHALL verify (macro defined): I op=0x3F -> no output word, err=1 one cycle, err_cnt=1; 300 illegal sets -> err_cnt=255.

Source files
------------

// File: rtl/inst_encoder.sv
// Encodes R/I/J field sets into 32-bit instruction words, buffers them in a 2-entry FIFO
// and streams them out with word addresses. Define INST_ENCODER_CHECK_EN for opcode checking.
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_fmt,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_func,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [9:0]  out_addr,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_RSV = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        ready_en;
  logic [31:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [9:0]  addr;
  logic [31:0] enc_word;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    enc_word = {in_op, in_rs, in_rt, in_imm};
    case (in_fmt)
      FMT_R:          enc_word = {6'b0, in_rs, in_rt, in_rd, in_shamt, in_func};
      FMT_J:          enc_word = {in_op, in_target};
      FMT_I, FMT_RSV: enc_word = {in_op, in_rs, in_rt, in_imm};
    endcase
  end

`ifdef INST_ENCODER_CHECK_EN
  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43: op_legal = 1'b1;
      default: op_legal = (op >= 6'd1) && (op <= 6'd15);
    endcase
  endfunction

  always_comb begin
    case (in_fmt)
      FMT_I:   legal = op_legal(in_op);
      FMT_J:   legal = (in_op == 6'd2) || (in_op == 6'd3);
      FMT_RSV: legal = 1'b0;
      default: legal = 1'b1;
    endcase
  end

  // Rejected sets are consumed (handshake completes) but never reach the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign legal   = 1'b1;
  assign err     = 1'b0;
  assign err_cnt = 8'd0;
`endif

  assign in_ready  = ready_en && ((state == IDLE) || (state == RUN)) && (count != 2'd2);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_word  = fifo_mem[rd_ptr];
  assign out_addr  = addr;

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The address tracks output handshakes, not FIFO slots, so it stays stable under stall.
  always_ff @(posedge clk) begin
    if (!rst_n)
      addr <= 10'd0;
    else if (state == DONE)
      addr <= 10'd0;
    else if (pop)
      addr <= addr + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept)
          state_next = in_last ? FLUSH : RUN;
      end
      RUN: begin
        if (accept && in_last)
          state_next = FLUSH;
      end
      FLUSH: begin
        if (count == 2'd0)
          state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (default build; INST_ENCODER_CHECK_EN adds
// the opcode-rejection scenario).
module tb_inst_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [5:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [5:0]  in_func;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [9:0]  out_addr;
  logic        done;
  logic        err;
  logic [7:0]  err_cnt;

  int          tests_run;
  int          tests_failed;
  logic [9:0]  exp_addr;

  inst_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_func   (in_func),
    .in_imm    (in_imm),
    .in_target (in_target),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called at a negedge; holds the set until accepted, returns at the negedge after acceptance.
  task automatic drive_set(input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] shamt,
                           input logic [5:0] func, input logic [15:0] imm,
                           input logic [25:0] target, input logic last, output bit accepted);
    int guard;
    in_fmt = fmt; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = shamt;
    in_func = func; in_imm = imm; in_target = target; in_last = last;
    in_valid = 1'b1;
    accepted = 1'b0;
    guard = 0;
    while (!accepted && guard < 50) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        accepted = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    in_fmt = 2'd0; in_op = 6'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
    in_shamt = 5'd0; in_func = 6'd0; in_imm = 16'd0; in_target = 26'd0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++;
    if (done !== 1'b0 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done_err: got %b/%b want 0/0", done, err); end
    tests_run++;
    if (err_cnt !== 8'd0 || out_addr !== 10'd0) begin tests_failed++; $display("[TB] FAIL reset_cnt_addr: got %0d/%0d want 0/0", err_cnt, out_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_in_ready: got %b want 1", in_ready); end
    exp_addr = 10'd0;
  endtask

  task automatic test_i_type();
    bit acc;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL i_pre_valid: got %b want 0", out_valid); end
    drive_set(2'd1, 6'd8, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0, acc);
    tests_run++;
    if (!acc || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL i_latency: accepted %b out_valid %b want 1/1", acc, out_valid); end
    tests_run++;
    if (out_word !== 32'h21280005) begin tests_failed++; $display("[TB] FAIL i_word: got %h want 21280005", out_word); end
    tests_run++;
    if (out_addr !== 10'd0) begin tests_failed++; $display("[TB] FAIL i_addr: got %0d want 0", out_addr); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_addr = exp_addr + 10'd1;
    tests_run++;
    if (out_valid !== 1'b0 || out_addr !== exp_addr) begin tests_failed++; $display("[TB] FAIL i_pop: valid %b addr %0d want 0/%0d", out_valid, out_addr, exp_addr); end
  endtask

  task automatic test_r_type();
    bit acc;
    drive_set(2'd0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF, 1'b0, acc);
    tests_run++;
    if (!acc || out_word !== 32'h00221820) begin tests_failed++; $display("[TB] FAIL r_word: accepted %b got %h want 00221820", acc, out_word); end
    tests_run++;
    if (out_addr !== exp_addr) begin tests_failed++; $display("[TB] FAIL r_addr: got %0d want %0d", out_addr, exp_addr); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_addr = exp_addr + 10'd1;
  endtask

  task automatic test_fmt3();
    bit acc;
`ifndef INST_ENCODER_CHECK_EN
    drive_set(2'd3, 6'd8, 5'd9, 5'd8, 5'd7, 5'd6, 6'd5, 16'd5, 26'd0, 1'b0, acc);
    tests_run++;
    if (!acc || out_word !== 32'h21280005) begin tests_failed++; $display("[TB] FAIL fmt3_as_i: accepted %b got %h want 21280005", acc, out_word); end
    tests_run++;
    if (err !== 1'b0 || err_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL fmt3_no_err: got %b/%0d want 0/0", err, err_cnt); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_addr = exp_addr + 10'd1;
`else
    acc = 1'b0;
`endif
  endtask

  task automatic test_j_last();
    bit acc;
    drive_set(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0100000, 1'b1, acc);
    tests_run++;
    if (!acc || out_word !== 32'h08100000) begin tests_failed++; $display("[TB] FAIL j_word: accepted %b got %h want 08100000", acc, out_word); end
    tests_run++;
    if (out_addr !== exp_addr || in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL j_flush: addr %0d in_ready %b want %0d/0", out_addr, in_ready, exp_addr); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL j_drain: valid %b done %b want 0/0", out_valid, done); end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL j_done: done %b in_ready %b want 1/0", done, in_ready); end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || out_addr !== 10'd0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL j_idle: done %b addr %0d in_ready %b want 0/0/1", done, out_addr, in_ready); end
    exp_addr = 10'd0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_fmt = 2'd1; in_op = 6'd8; in_rs = 5'd1; in_rt = 5'd0; in_last = 1'b0;
    in_imm = 16'h000A; in_valid = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_accept_a: in_ready %b want 1", in_ready); end
    @(negedge clk);
    in_imm = 16'h000B;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_accept_b: in_ready %b want 1", in_ready); end
    @(negedge clk);
    in_imm = 16'h000C;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (in_ready !== 1'b0 || out_word !== 32'h2020000A || out_addr !== 10'd0) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_%0d: in_ready %b word %h addr %0d want 0/2020000a/0", k, in_ready, out_word, out_addr);
      end
      if (k == 3) out_ready = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (out_word !== 32'h2020000B || out_addr !== 10'd1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_second: word %h addr %0d in_ready %b want 2020000b/1/1", out_word, out_addr, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_word !== 32'h2020000C || out_addr !== 10'd2) begin
      tests_failed++;
      $display("[TB] FAIL bp_third: valid %b word %h addr %0d want 1/2020000c/2", out_valid, out_word, out_addr);
    end
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_addr !== 10'd3) begin tests_failed++; $display("[TB] FAIL bp_empty: valid %b addr %0d want 0/3", out_valid, out_addr); end
  endtask

  task automatic test_reset_mid();
    bit acc;
    drive_set(2'd1, 6'd9, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0, acc);
    tests_run++;
    if (!acc || out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_buffered: accepted %b valid %b want 1/1", acc, out_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || out_addr !== 10'd0 || in_ready !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: valid %b addr %0d in_ready %b done %b want 0/0/0/0", out_valid, out_addr, in_ready, done);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_no_done_%0d: done %b valid %b want 0/0", k, done, out_valid); end
    end
  endtask

  task automatic test_stream();
    bit stop;
    int got;
    stop = 1'b0;
    got = 0;
    out_ready = 1'b1;
    fork
      begin
        bit acc;
        for (int k = 0; k < 1025 && !stop; k++) begin
          logic [15:0] kk;
          kk = k[15:0];
          drive_set(2'd1, 6'd8, kk[4:0], 5'd0, 5'd0, 5'd0, 6'd0, kk, 26'd0, (k == 1024), acc);
          if (!acc) begin
            stop = 1'b1;
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL stream_accept: set %0d not accepted within bound", k);
          end
        end
      end
      begin
        int guard;
        guard = 0;
        while (got < 1025 && guard < 4000 && !stop) begin
          @(negedge clk);
          guard++;
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            logic [15:0] gg;
            logic [9:0]  ea;
            gg = got[15:0];
            ea = got[9:0];
            tests_run++;
            if (out_addr !== ea || out_word !== {6'd8, gg[4:0], 5'd0, gg}) begin
              tests_failed++;
              $display("[TB] FAIL stream_word_%0d: addr %0d word %h want %0d/%h", got, out_addr, out_word, ea, {6'd8, gg[4:0], 5'd0, gg});
            end
            got++;
          end
        end
      end
    join
    tests_run++;
    if (got != 1025) begin tests_failed++; $display("[TB] FAIL stream_count: got %0d words want 1025", got); end
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (done === 1'b1) seen = 1'b1;
      end
      tests_run++;
      if (!seen) begin tests_failed++; $display("[TB] FAIL stream_done: done %b want 1 within bound", done); end
      @(negedge clk);
      tests_run++;
      if (out_addr !== 10'd0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL stream_addr_back: addr %0d done %b want 0/0", out_addr, done); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_check();
`ifdef INST_ENCODER_CHECK_EN
    bit acc;
    drive_set(2'd1, 6'h3F, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0, acc);
    tests_run++;
    if (!acc || err !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL chk_reject: accepted %b err %b valid %b want 1/1/0", acc, err, out_valid); end
    tests_run++;
    if (err_cnt !== 8'd1) begin tests_failed++; $display("[TB] FAIL chk_cnt1: got %0d want 1", err_cnt); end
    @(negedge clk);
    tests_run++;
    if (err !== 1'b0 || out_addr !== 10'd0) begin tests_failed++; $display("[TB] FAIL chk_pulse: err %b addr %0d want 0/0", err, out_addr); end
    for (int k = 0; k < 299; k++) begin
      case (k % 3)
        0:       drive_set(2'd3, 6'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0, acc);
        1:       drive_set(2'd1, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0, acc);
        default: drive_set(2'd2, 6'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0, acc);
      endcase
    end
    @(negedge clk);
    tests_run++;
    if (err_cnt !== 8'd255 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL chk_saturate: err_cnt %0d valid %b want 255/0", err_cnt, out_valid); end
`else
    tests_run++;
    if (err !== 1'b0 || err_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL chk_tied: err %b err_cnt %0d want 0/0", err, err_cnt); end
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_addr     = 10'd0;
    test_reset();
    test_i_type();
    test_r_type();
    test_fmt3();
    test_j_last();
    test_backpressure();
    test_reset_mid();
    test_stream();
    test_check();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
